// File: rtl/urv_mdu_if.sv
// urv_mdu_if: X-stage handshake plus operand/result bus between the core
// pipeline (master) and the multiply/divide unit (slave).
interface urv_mdu_if #(
  parameter int g_width = 32
);
  logic               x_stall_i;
  logic               x_kill_i;
  logic               d_valid_i;
  logic               d_is_multiply_i;
  logic               d_is_divide_i;
  logic [2:0]         d_fun_i;
  logic [g_width-1:0] d_rs1_i;
  logic [g_width-1:0] d_rs2_i;
  logic               x_stall_req_o;
  logic [g_width-1:0] x_rd_o;
  logic               x_rd_valid_o;
  logic               busy_o;

  modport master (
    output x_stall_i, x_kill_i, d_valid_i, d_is_multiply_i, d_is_divide_i,
           d_fun_i, d_rs1_i, d_rs2_i,
    input  x_stall_req_o, x_rd_o, x_rd_valid_o, busy_o
  );

  modport slave (
    input  x_stall_i, x_kill_i, d_valid_i, d_is_multiply_i, d_is_divide_i,
           d_fun_i, d_rs1_i, d_rs2_i,
    output x_stall_req_o, x_rd_o, x_rd_valid_o, busy_o
  );
endinterface

// File: rtl/urv_mdu.sv
// urv_mdu: iterative RISC-V M-extension unit. Multiplies by shift-add and
// divides by restoring division on operand magnitudes, retiring
// g_bits_per_cycle bits per cycle, then sign-corrects the result.
// Zero multiplies, divide-by-zero and signed overflow can complete early.
module urv_mdu #(
  parameter int g_width          = 32,
  parameter int g_bits_per_cycle = 1,
  parameter int g_fast_paths     = 1
) (
  input logic      clk_i,
  input logic      rst_i,
  urv_mdu_if.slave mdu
);

  localparam int N  = g_width / g_bits_per_cycle;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0]      CNT_N    = CW'(N);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [g_width-1:0] ALL_ONES = {g_width{1'b1}};
  localparam logic [g_width-1:0] ZERO_W   = {g_width{1'b0}};
  localparam logic [g_width-1:0] MOST_NEG = {1'b1, {(g_width-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [g_width-1:0] neg_w(input logic [g_width-1:0] v);
    return ~v + {{(g_width-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*g_width-1:0] neg_2w(input logic [2*g_width-1:0] v);
    return ~v + {{(2*g_width-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [g_width-1:0] hi_q, hi_d;     // product high half / partial remainder
  logic [g_width-1:0] lo_q, lo_d;     // multiplier-product low half / dividend-quotient
  logic [g_width-1:0] opa_q, opa_d;   // multiplicand or divisor magnitude
  logic [g_width-1:0] rd_q, rd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rd_valid_q, rd_valid_d;
  logic [1:0]         fun_q, fun_d;

  logic               start, rs1_signed, rs2_signed, sign1, sign2;
  logic               rs1_zero, rs2_zero, div_ovf, fast_hit, neg_start;
  logic [g_width-1:0] mag1, mag2, fast_res;
  logic [g_width-1:0] hi_it, lo_it, div_raw, final_res;
  logic [g_width:0]   rem_sh, sum;
  logic [2*g_width-1:0] prod, prod_c;

  // Decode the incoming instruction: signedness, magnitudes, result sign and early result.
  always_comb begin
    case (mdu.d_fun_i)
      3'd1, 3'd4, 3'd6: begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
      3'd2:             begin rs1_signed = 1'b1; rs2_signed = 1'b0; end
      default:          begin rs1_signed = 1'b0; rs2_signed = 1'b0; end
    endcase
    sign1    = rs1_signed & mdu.d_rs1_i[g_width-1];
    sign2    = rs2_signed & mdu.d_rs2_i[g_width-1];
    mag1     = sign1 ? neg_w(mdu.d_rs1_i) : mdu.d_rs1_i;
    mag2     = sign2 ? neg_w(mdu.d_rs2_i) : mdu.d_rs2_i;
    rs1_zero = (mdu.d_rs1_i == ZERO_W);
    rs2_zero = (mdu.d_rs2_i == ZERO_W);
    div_ovf  = mdu.d_is_divide_i & rs1_signed & (mdu.d_rs1_i == MOST_NEG) &
               (mdu.d_rs2_i == ALL_ONES);
    if (mdu.d_is_divide_i) begin
      // A zero divisor yields an all-ones quotient, so its sign is never applied.
      if (mdu.d_fun_i[1]) begin
        neg_start = sign1;
      end else begin
        neg_start = (sign1 ^ sign2) & ~rs2_zero;
      end
      if (rs2_zero) begin
        fast_res = mdu.d_fun_i[1] ? mdu.d_rs1_i : ALL_ONES;
      end else if (div_ovf) begin
        fast_res = mdu.d_fun_i[1] ? ZERO_W : mdu.d_rs1_i;
      end else begin
        fast_res = ZERO_W;
      end
      fast_hit = (g_fast_paths != 0) & (rs2_zero | div_ovf);
    end else begin
      neg_start = sign1 ^ sign2;
      fast_res  = ZERO_W;
      fast_hit  = (g_fast_paths != 0) & (rs1_zero | rs2_zero);
    end
    start = mdu.d_valid_i & (mdu.d_is_multiply_i | mdu.d_is_divide_i) &
            ~mdu.x_kill_i & (state_q == S_IDLE);
  end

  // Retire g_bits_per_cycle shift-add or restoring-divide steps from the held state.
  always_comb begin
    hi_it  = hi_q;
    lo_it  = lo_q;
    rem_sh = {(g_width+1){1'b0}};
    sum    = {(g_width+1){1'b0}};
    for (int i = 0; i < g_bits_per_cycle; i++) begin
      if (is_div_q) begin
        rem_sh = {hi_it, lo_it[g_width-1]};
        lo_it  = {lo_it[g_width-2:0], 1'b0};
        if (rem_sh >= {1'b0, opa_q}) begin
          hi_it    = rem_sh[g_width-1:0] - opa_q;
          lo_it[0] = 1'b1;
        end else begin
          hi_it = rem_sh[g_width-1:0];
        end
      end else begin
        sum   = {1'b0, hi_it} + (lo_it[0] ? {1'b0, opa_q} : {(g_width+1){1'b0}});
        lo_it = {sum[0], lo_it[g_width-1:1]};
        hi_it = sum[g_width:1];
      end
    end
  end

  // Sign-correct the final iteration and select product half, quotient or remainder.
  always_comb begin
    prod    = {hi_it, lo_it};
    prod_c  = neg_q ? neg_2w(prod) : prod;
    div_raw = fun_q[1] ? hi_it : lo_it;
    if (is_div_q) begin
      final_res = neg_q ? neg_w(div_raw) : div_raw;
    end else if (fun_q == 2'd0) begin
      final_res = prod_c[g_width-1:0];
    end else begin
      final_res = prod_c[2*g_width-1:g_width];
    end
  end

  // Next-state logic: kill wins, IDLE latches operands, BUSY iterates, DONE waits for the pipeline.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opa_d      = opa_q;
    is_div_d   = is_div_q;
    fun_d      = fun_q;
    neg_d      = neg_q;
    rd_d       = rd_q;
    rd_valid_d = rd_valid_q;
    if (mdu.x_kill_i) begin
      state_d    = S_IDLE;
      cnt_d      = CNT_ZERO;
      rd_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_d = mdu.d_is_divide_i;
            fun_d    = mdu.d_fun_i[1:0];
            neg_d    = neg_start;
            hi_d     = ZERO_W;
            lo_d     = mdu.d_is_divide_i ? mag1 : mag2;
            opa_d    = mdu.d_is_divide_i ? mag2 : mag1;
            if (fast_hit) begin
              state_d    = S_DONE;
              cnt_d      = CNT_ZERO;
              rd_d       = fast_res;
              rd_valid_d = 1'b1;
            end else begin
              state_d = S_BUSY;
              cnt_d   = CNT_N;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          hi_d = hi_it;
          lo_d = lo_it;
          if (cnt_q <= CNT_ONE) begin
            state_d    = S_DONE;
            cnt_d      = CNT_ZERO;
            rd_d       = final_res;
            rd_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          if (!mdu.x_stall_i) begin
            state_d    = S_IDLE;
            rd_valid_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d    = S_IDLE;
          cnt_d      = CNT_ZERO;
          rd_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and result registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      hi_q       <= ZERO_W;
      lo_q       <= ZERO_W;
      opa_q      <= ZERO_W;
      is_div_q   <= 1'b0;
      fun_q      <= 2'd0;
      neg_q      <= 1'b0;
      rd_q       <= ZERO_W;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opa_q      <= opa_d;
      is_div_q   <= is_div_d;
      fun_q      <= fun_d;
      neg_q      <= neg_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign mdu.x_stall_req_o = (start | (state_q == S_BUSY)) & ~mdu.x_kill_i;
  assign mdu.busy_o        = (state_q == S_BUSY);
  assign mdu.x_rd_o        = rd_q;
  assign mdu.x_rd_valid_o  = rd_valid_q;

endmodule

// File: tb/tb_urv_mdu.sv
// tb_urv_mdu: directed bench for urv_mdu. Three instances share the same
// stimulus: k=1 with fast paths, k=4 with fast paths, k=4 without.
module tb_urv_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_valid = 1'b0, d_mul = 1'b0, d_div = 1'b0;
  logic        x_stall = 1'b0, x_kill = 1'b0;
  logic [2:0]  d_fun = 3'd0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [2:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          st1;
    int          st4;
    int          stn;
  } vec_t;

  always #5 clk = ~clk;

  urv_mdu_if #(.g_width(32)) if_k1 ();
  urv_mdu_if #(.g_width(32)) if_k4 ();
  urv_mdu_if #(.g_width(32)) if_nf ();

  assign if_k1.x_stall_i = x_stall;  assign if_k4.x_stall_i = x_stall;  assign if_nf.x_stall_i = x_stall;
  assign if_k1.x_kill_i  = x_kill;   assign if_k4.x_kill_i  = x_kill;   assign if_nf.x_kill_i  = x_kill;
  assign if_k1.d_valid_i = d_valid;  assign if_k4.d_valid_i = d_valid;  assign if_nf.d_valid_i = d_valid;
  assign if_k1.d_is_multiply_i = d_mul; assign if_k4.d_is_multiply_i = d_mul; assign if_nf.d_is_multiply_i = d_mul;
  assign if_k1.d_is_divide_i   = d_div; assign if_k4.d_is_divide_i   = d_div; assign if_nf.d_is_divide_i   = d_div;
  assign if_k1.d_fun_i = d_fun;      assign if_k4.d_fun_i = d_fun;      assign if_nf.d_fun_i = d_fun;
  assign if_k1.d_rs1_i = rs1;        assign if_k4.d_rs1_i = rs1;        assign if_nf.d_rs1_i = rs1;
  assign if_k1.d_rs2_i = rs2;        assign if_k4.d_rs2_i = rs2;        assign if_nf.d_rs2_i = rs2;

  urv_mdu #(.g_width(32), .g_bits_per_cycle(1), .g_fast_paths(1)) u_k1 (.clk_i(clk), .rst_i(rst), .mdu(if_k1.slave));
  urv_mdu #(.g_width(32), .g_bits_per_cycle(4), .g_fast_paths(1)) u_k4 (.clk_i(clk), .rst_i(rst), .mdu(if_k4.slave));
  urv_mdu #(.g_width(32), .g_bits_per_cycle(4), .g_fast_paths(0)) u_nf (.clk_i(clk), .rst_i(rst), .mdu(if_nf.slave));

  logic [2:0]  busy3, valid3, stall3;
  logic [95:0] rd96;
  assign busy3  = {if_k1.busy_o, if_k4.busy_o, if_nf.busy_o};
  assign valid3 = {if_k1.x_rd_valid_o, if_k4.x_rd_valid_o, if_nf.x_rd_valid_o};
  assign stall3 = {if_k1.x_stall_req_o, if_k4.x_stall_req_o, if_nf.x_stall_req_o};
  assign rd96   = {if_k1.x_rd_o, if_k4.x_rd_o, if_nf.x_rd_o};

  // Issue one instruction for a single cycle and observe 40 cycles on all instances.
  task automatic run_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r4, output logic [31:0] rn,
                        output int s1, output int s4, output int sn,
                        output int v1, output int v4, output int vn);
    s1 = 0; s4 = 0; sn = 0; v1 = 0; v4 = 0; vn = 0;
    r1 = 32'd0; r4 = 32'd0; rn = 32'd0;
    @(posedge clk); #1;
    d_valid = 1'b1; d_mul = ~fun[2]; d_div = fun[2]; d_fun = fun; rs1 = a; rs2 = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_k1.x_stall_req_o) s1++;
      if (if_k4.x_stall_req_o) s4++;
      if (if_nf.x_stall_req_o) sn++;
      if (if_k1.x_rd_valid_o) begin v1++; r1 = if_k1.x_rd_o; end
      if (if_k4.x_rd_valid_o) begin v4++; r4 = if_k4.x_rd_o; end
      if (if_nf.x_rd_valid_o) begin vn++; rn = if_nf.x_rd_o; end
      @(posedge clk); #1;
      d_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rd96 !== 96'd0) begin bad++; $display("FAIL reset_rd: got %h want 0", rd96); end
    total++; if (valid3 !== 3'b000) begin bad++; $display("FAIL reset_valid: got %b want 000", valid3); end
    total++; if (busy3 !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", busy3); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (stall3 !== 3'b000) begin bad++; $display("FAIL reset_idle_stall: got %b want 000", stall3); end
    total++; if (busy3 !== 3'b000) begin bad++; $display("FAIL reset_idle_busy: got %b want 000", busy3); end
  endtask

  task automatic test_multiply;
    vec_t tv[7];
    logic [31:0] r1, r4, rn;
    int s1, s4, sn, v1, v4, vn;
    tv[0] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 9, 9};
    tv[1] = '{3'd0, 32'd3,        32'd4,        32'd12,       33, 9, 9};
    tv[2] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33, 9, 9};
    tv[3] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33, 9, 9};
    tv[4] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 9, 9};
    tv[5] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 9, 9};
    tv[6] = '{3'd3, 32'h80000000, 32'd2,        32'h00000001, 33, 9, 9};
    foreach (tv[i]) begin
      run_op(tv[i].fun, tv[i].a, tv[i].b, r1, r4, rn, s1, s4, sn, v1, v4, vn);
      total++; if ({r1, r4, rn} !== {3{tv[i].exp}}) begin bad++; $display("FAIL mul[%0d] result: got %h/%h/%h want %h", i, r1, r4, rn, tv[i].exp); end
      total++; if ({s1, s4, sn} !== {tv[i].st1, tv[i].st4, tv[i].stn}) begin bad++; $display("FAIL mul[%0d] stalls: got %0d/%0d/%0d want %0d/%0d/%0d", i, s1, s4, sn, tv[i].st1, tv[i].st4, tv[i].stn); end
      total++; if (v1 !== 1 || v4 !== 1 || vn !== 1) begin bad++; $display("FAIL mul[%0d] valid_cycles: got %0d/%0d/%0d want 1/1/1", i, v1, v4, vn); end
    end
  endtask

  task automatic test_divide;
    vec_t tv[8];
    logic [31:0] r1, r4, rn;
    int s1, s4, sn, v1, v4, vn;
    tv[0] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 9, 9};
    tv[1] = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 9, 9};
    tv[2] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 9, 9};
    tv[3] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 9, 9};
    tv[4] = '{3'd5, 32'd100,      32'd7,        32'd14,       33, 9, 9};
    tv[5] = '{3'd7, 32'd100,      32'd7,        32'd2,        33, 9, 9};
    tv[6] = '{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 9, 9};
    tv[7] = '{3'd5, 32'd0,        32'd5,        32'd0,        33, 9, 9};
    foreach (tv[i]) begin
      run_op(tv[i].fun, tv[i].a, tv[i].b, r1, r4, rn, s1, s4, sn, v1, v4, vn);
      total++; if ({r1, r4, rn} !== {3{tv[i].exp}}) begin bad++; $display("FAIL div[%0d] result: got %h/%h/%h want %h", i, r1, r4, rn, tv[i].exp); end
      total++; if ({s1, s4, sn} !== {tv[i].st1, tv[i].st4, tv[i].stn}) begin bad++; $display("FAIL div[%0d] stalls: got %0d/%0d/%0d want %0d/%0d/%0d", i, s1, s4, sn, tv[i].st1, tv[i].st4, tv[i].stn); end
      total++; if (v1 !== 1 || v4 !== 1 || vn !== 1) begin bad++; $display("FAIL div[%0d] valid_cycles: got %0d/%0d/%0d want 1/1/1", i, v1, v4, vn); end
    end
  endtask

  task automatic test_fast_paths;
    vec_t tv[8];
    logic [31:0] r1, r4, rn;
    int s1, s4, sn, v1, v4, vn;
    tv[0] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1, 9};
    tv[1] = '{3'd7, 32'd5,        32'd0,        32'd5,        1, 1, 9};
    tv[2] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, 9};
    tv[3] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1, 9};
    tv[4] = '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 1, 9};
    tv[5] = '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1, 1, 9};
    tv[6] = '{3'd0, 32'd0,        32'h00001234, 32'd0,        1, 1, 9};
    tv[7] = '{3'd1, 32'hFFFFFFFF, 32'd0,        32'd0,        1, 1, 9};
    foreach (tv[i]) begin
      run_op(tv[i].fun, tv[i].a, tv[i].b, r1, r4, rn, s1, s4, sn, v1, v4, vn);
      total++; if ({r1, r4, rn} !== {3{tv[i].exp}}) begin bad++; $display("FAIL fast[%0d] result: got %h/%h/%h want %h", i, r1, r4, rn, tv[i].exp); end
      total++; if ({s1, s4, sn} !== {tv[i].st1, tv[i].st4, tv[i].stn}) begin bad++; $display("FAIL fast[%0d] stalls: got %0d/%0d/%0d want %0d/%0d/%0d", i, s1, s4, sn, tv[i].st1, tv[i].st4, tv[i].stn); end
      total++; if (v1 !== 1 || v4 !== 1 || vn !== 1) begin bad++; $display("FAIL fast[%0d] valid_cycles: got %0d/%0d/%0d want 1/1/1", i, v1, v4, vn); end
    end
  endtask

  task automatic test_kill;
    int late = 0;
    @(posedge clk); #1;
    d_valid = 1'b1; d_mul = 1'b1; d_div = 1'b0; d_fun = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    @(posedge clk); #1;
    d_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; x_kill = 1'b1;
    @(negedge clk);
    total++; if (busy3 !== 3'b111) begin bad++; $display("FAIL kill_busy_before: got %b want 111", busy3); end
    total++; if (stall3 !== 3'b000) begin bad++; $display("FAIL kill_stall_same_cycle: got %b want 000", stall3); end
    @(posedge clk); #1;
    x_kill = 1'b0;
    @(negedge clk);
    total++; if (busy3 !== 3'b000) begin bad++; $display("FAIL kill_idle_next: got %b want 000", busy3); end
    total++; if (valid3 !== 3'b000) begin bad++; $display("FAIL kill_valid_next: got %b want 000", valid3); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy3 != 3'b000 || valid3 != 3'b000) late++;
    end
    total++; if (late !== 0) begin bad++; $display("FAIL kill_stays_idle: got %0d active cycles want 0", late); end
    @(posedge clk); #1;
    d_valid = 1'b1; x_kill = 1'b1;
    @(negedge clk);
    total++; if (stall3 !== 3'b000) begin bad++; $display("FAIL kill_with_start_stall: got %b want 000", stall3); end
    @(posedge clk); #1;
    d_valid = 1'b0; x_kill = 1'b0;
    @(negedge clk);
    total++; if (busy3 !== 3'b000) begin bad++; $display("FAIL kill_with_start_busy: got %b want 000", busy3); end
  endtask

  task automatic test_stall_hold;
    int v1 = 0, v4 = 0, vn = 0, rd_bad = 0, late_stall = 0, late_busy = 0;
    @(posedge clk); #1;
    d_valid = 1'b1; d_mul = 1'b1; d_div = 1'b0; d_fun = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    for (int c = 0; c <= 45; c++) begin
      x_stall = (c >= 9 && c <= 11);
      @(negedge clk);
      if (if_k1.x_rd_valid_o) begin v1++; if (if_k1.x_rd_o !== 32'd12) rd_bad++; end
      if (if_k4.x_rd_valid_o) begin v4++; if (if_k4.x_rd_o !== 32'd12) rd_bad++; end
      if (if_nf.x_rd_valid_o) begin vn++; if (if_nf.x_rd_o !== 32'd12) rd_bad++; end
      if (c >= 9 && (if_k4.x_stall_req_o || if_nf.x_stall_req_o)) late_stall++;
      if (c >= 13 && (if_k4.busy_o || if_nf.busy_o)) late_busy++;
      @(posedge clk); #1;
      d_valid = 1'b0;
    end
    x_stall = 1'b0;
    total++; if (v1 !== 1 || v4 !== 4 || vn !== 4) begin bad++; $display("FAIL hold_valid_cycles: got %0d/%0d/%0d want 1/4/4", v1, v4, vn); end
    total++; if (rd_bad !== 0) begin bad++; $display("FAIL hold_rd_value: got %0d wrong samples want 0", rd_bad); end
    total++; if (late_stall !== 0) begin bad++; $display("FAIL hold_no_stall_in_done: got %0d want 0", late_stall); end
    total++; if (late_busy !== 0) begin bad++; $display("FAIL hold_no_restart: got %0d busy cycles want 0", late_busy); end
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] r1, r4, rn;
    int s1, s4, sn, v1, v4, vn;
    @(posedge clk); #1;
    d_valid = 1'b1; d_mul = 1'b1; d_div = 1'b0; d_fun = 3'd3; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    d_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total++; if (busy3 !== 3'b111) begin bad++; $display("FAIL rstmid_busy_before: got %b want 111", busy3); end
    #1; rst = 1'b1;
    #1;
    total++; if (busy3 !== 3'b000) begin bad++; $display("FAIL rstmid_busy: got %b want 000", busy3); end
    total++; if (valid3 !== 3'b000 || stall3 !== 3'b000) begin bad++; $display("FAIL rstmid_valid_stall: got %b/%b want 000/000", valid3, stall3); end
    total++; if (rd96 !== 96'd0) begin bad++; $display("FAIL rstmid_rd: got %h want 0", rd96); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, r1, r4, rn, s1, s4, sn, v1, v4, vn);
    total++; if ({r1, r4, rn} !== {3{32'hFFFFFFFF}}) begin bad++; $display("FAIL rstmid_mulhsu: got %h/%h/%h want ffffffff", r1, r4, rn); end
    total++; if ({s1, s4, sn} !== {32'sd33, 32'sd9, 32'sd9}) begin bad++; $display("FAIL rstmid_stalls: got %0d/%0d/%0d want 33/9/9", s1, s4, sn); end
    total++; if (v1 !== 1 || v4 !== 1 || vn !== 1) begin bad++; $display("FAIL rstmid_valid_cycles: got %0d/%0d/%0d want 1/1/1", v1, v4, vn); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_fast_paths();
    test_kill();
    test_stall_hold();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
